// File: rtl/beam_trigger_scaler.sv
//------------------------------------------------------------------------------
// beam_trigger_scaler: per-beam holdoff-qualified trigger gating with gated
// saturating rate counters, snapshot registers and a one-cycle read port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module beam_trigger_scaler #(
  parameter int NBEAMS        = 8,
  parameter int COUNT_WIDTH   = 32,
  parameter int HOLDOFF_WIDTH = 8,
  parameter int PERIOD_WIDTH  = 32,
  localparam int IDX_WIDTH    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NBEAMS-1:0]        trig_i,
  input  logic [NBEAMS-1:0]        mask_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic [PERIOD_WIDTH-1:0]  period_i,
  input  logic                     mode_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     rd_req_i,
  input  logic [IDX_WIDTH-1:0]     rd_idx_i,
  output logic [NBEAMS-1:0]        trig_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_ack_o,
  output logic [COUNT_WIDTH-1:0]   rd_dat_o,
  output logic [15:0]              snap_seq_o
);

  localparam logic [PERIOD_WIDTH-1:0]  PERIOD_ONE = 1;
  localparam logic [HOLDOFF_WIDTH-1:0] HOLD_ONE   = 1;
  localparam logic [COUNT_WIDTH-1:0]   COUNT_ONE  = 1;
  localparam logic [15:0]              SEQ_ONE    = 16'd1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                   state;
  logic [NBEAMS-1:0]        accept;
  logic [HOLDOFF_WIDTH-1:0] holdoff  [NBEAMS];
  logic [COUNT_WIDTH-1:0]   count    [NBEAMS];
  logic [COUNT_WIDTH-1:0]   snapshot [NBEAMS];
  logic [PERIOD_WIDTH-1:0]  gate_cnt;
  logic [PERIOD_WIDTH-1:0]  gate_load;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] value,
    input logic                   inc
  );
    return (inc && (value != '1)) ? value + COUNT_ONE : value;
  endfunction

  always_comb begin
    accept = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      accept[b] = trig_i[b] & ~mask_i[b] & (holdoff[b] == '0);
    end
  end

  // A zero period behaves as a one-cycle gate.
  assign gate_load = (period_i == '0) ? '0 : period_i - PERIOD_ONE;
  assign busy_o    = (state == COUNT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trig_o <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        holdoff[b] <= '0;
      end
    end else begin
      trig_o <= accept;
      for (int b = 0; b < NBEAMS; b++) begin
        if (accept[b]) begin
          holdoff[b] <= holdoff_i;
        end else if (holdoff[b] != '0) begin
          holdoff[b] <= holdoff[b] - HOLD_ONE;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      done_o     <= 1'b0;
      snap_seq_o <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        count[b]    <= '0;
        snapshot[b] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            state    <= COUNT;
            gate_cnt <= gate_load;
            for (int b = 0; b < NBEAMS; b++) begin
              count[b] <= '0;
            end
          end
        end
        COUNT: begin
          if (gate_cnt == '0) begin
            // Final gate cycle: this cycle's accepts still belong to the gate.
            for (int b = 0; b < NBEAMS; b++) begin
              snapshot[b] <= sat_inc(count[b], accept[b]);
              count[b]    <= '0;
            end
            snap_seq_o <= snap_seq_o + SEQ_ONE;
            done_o     <= 1'b1;
            if (!stop_i && (mode_i || start_i)) begin
              gate_cnt <= gate_load;
            end else begin
              state <= IDLE;
            end
          end else if (stop_i) begin
            state <= IDLE;
            for (int b = 0; b < NBEAMS; b++) begin
              count[b] <= '0;
            end
          end else if (start_i) begin
            gate_cnt <= gate_load;
            for (int b = 0; b < NBEAMS; b++) begin
              count[b] <= '0;
            end
          end else begin
            gate_cnt <= gate_cnt - PERIOD_ONE;
            for (int b = 0; b < NBEAMS; b++) begin
              count[b] <= sat_inc(count[b], accept[b]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ack_o <= 1'b0;
      rd_dat_o <= '0;
    end else begin
      rd_ack_o <= rd_req_i;
      if (rd_req_i) begin
        rd_dat_o <= (int'(rd_idx_i) < NBEAMS) ? snapshot[rd_idx_i] : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beam_trigger_scaler.sv
//------------------------------------------------------------------------------
// tb_beam_trigger_scaler: scenario bench with a read-back scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_beam_trigger_scaler;

  localparam int NB = 4;
  localparam int CW = 4;
  localparam int HW = 8;
  localparam int PW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [NB-1:0] trig_i, mask_i;
  logic [HW-1:0] holdoff_i;
  logic [PW-1:0] period_i;
  logic          mode_i, start_i, stop_i, rd_req_i;
  logic [1:0]    rd_idx_i;
  logic [NB-1:0] trig_o;
  logic          busy_o, done_o, rd_ack_o;
  logic [CW-1:0] rd_dat_o;
  logic [15:0]   snap_seq_o;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] rd_q[$];
  logic [CW-1:0] exp_v;
  bit            trig2_seen = 1'b0;
  int            k;

  beam_trigger_scaler #(
    .NBEAMS(NB), .COUNT_WIDTH(CW), .HOLDOFF_WIDTH(HW), .PERIOD_WIDTH(PW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .trig_i(trig_i), .mask_i(mask_i),
    .holdoff_i(holdoff_i), .period_i(period_i), .mode_i(mode_i),
    .start_i(start_i), .stop_i(stop_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o), .rd_ack_o(rd_ack_o),
    .rd_dat_o(rd_dat_o), .snap_seq_o(snap_seq_o)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic rd(input int idx, input logic [CW-1:0] exp);
    rd_req_i = 1'b1;
    rd_idx_i = idx[1:0];
    rd_q.push_back(exp);
    cyc();
    rd_req_i = 1'b0;
  endtask

  task automatic start_gate();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  // Read scoreboard: each ack retires the oldest outstanding expectation.
  always @(negedge aclk) begin
    if (aresetn && trig_o[2]) trig2_seen = 1'b1;
    if (rd_ack_o) begin
      if (rd_q.size() == 0) begin
        check_eq("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_v = rd_q.pop_front();
        check_eq("rd_dat", rd_dat_o, exp_v);
      end
    end
  end

  initial begin
    aresetn = 1'b0; trig_i = '0; mask_i = '0; holdoff_i = '0; period_i = '0;
    mode_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; rd_req_i = 1'b0; rd_idx_i = '0;
    cyc(); cyc();
    check_eq("rst_trig_o", trig_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_ack", rd_ack_o, 0);
    check_eq("rst_dat", rd_dat_o, 0);
    check_eq("rst_seq", snap_seq_o, 0);
    aresetn = 1'b1;
    cyc();

    // Holdoff 3, single-shot 20-cycle gate, trig 0 high for 10 cycles.
    holdoff_i = 8'd3; period_i = 16'd20; mode_i = 1'b0;
    start_gate();
    for (int c = 0; c < 25; c++) begin
      check_eq($sformatf("t43_trig0_c%0d", c), trig_o[0], (c == 1 || c == 5 || c == 9));
      check_eq($sformatf("t43_done_c%0d", c), done_o, (c == 20));
      check_eq($sformatf("t43_busy_c%0d", c), busy_o, (c < 20));
      trig_i[0] = (c < 10);
      cyc();
    end
    check_eq("t43_seq", snap_seq_o, 1);
    rd(0, 4'd3);
    cyc(); cyc();
    check_eq("rd_hold", rd_dat_o, 3);

    // Saturation on beam 1, masked beam 2.
    holdoff_i = 8'd0; period_i = 16'd32; mask_i = 4'b0100;
    start_gate();
    for (int c = 0; c < 34; c++) begin
      check_eq($sformatf("t44_done_c%0d", c), done_o, (c == 32));
      if (c < 24) check_eq($sformatf("t44_trig1_c%0d", c), trig_o[1], (c >= 1 && c <= 20));
      trig_i[1] = (c < 20);
      trig_i[2] = 1'b1;
      cyc();
    end
    trig_i = '0;
    check_eq("t44_seq", snap_seq_o, 2);
    check_eq("t44_trig2_never", trig2_seen, 0);
    rd(1, 4'd15);
    rd(2, 4'd0);
    rd(0, 4'd0);
    mask_i = '0;

    // Stop at cycle 7 of a 20-cycle gate.
    period_i = 16'd20;
    start_gate();
    for (int c = 0; c < 30; c++) begin
      check_eq($sformatf("t46_busy_c%0d", c), busy_o, (c < 8));
      check_eq($sformatf("t46_done_c%0d", c), done_o, 0);
      trig_i[1] = (c < 7);
      stop_i = (c == 7);
      cyc();
    end
    check_eq("t46_seq", snap_seq_o, 2);
    rd(1, 4'd15);
    start_i = 1'b1; stop_i = 1'b1;
    cyc();
    start_i = 1'b0; stop_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("t46_idle_busy", busy_o, 0);
      cyc();
    end

    // Read coinciding with the final gate cycle, then just after.
    period_i = 16'd6; trig_i[1] = 1'b1;
    start_gate();
    for (int c = 0; c < 8; c++) begin
      check_eq($sformatf("t47_done_c%0d", c), done_o, (c == 6));
      rd_req_i = (c == 5 || c == 6);
      rd_idx_i = 2'd1;
      if (c == 5) rd_q.push_back(4'd15);
      if (c == 6) rd_q.push_back(4'd6);
      cyc();
    end
    rd_req_i = 1'b0; trig_i = '0;
    check_eq("t47_seq", snap_seq_o, 3);

    // Asynchronous reset in the middle of a gate.
    period_i = 16'd20; trig_i[1] = 1'b1;
    start_gate();
    for (int c = 0; c < 10; c++) cyc();
    check_eq("t48_busy_pre", busy_o, 1);
    check_eq("t48_trig_pre", trig_o[1], 1);
    aresetn = 1'b0;
    #1;
    check_eq("t48_trig_o", trig_o, 0);
    check_eq("t48_busy", busy_o, 0);
    check_eq("t48_done", done_o, 0);
    check_eq("t48_ack", rd_ack_o, 0);
    check_eq("t48_dat", rd_dat_o, 0);
    check_eq("t48_seq", snap_seq_o, 0);
    cyc(); cyc();
    aresetn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      check_eq("t48_no_done", done_o, 0);
      check_eq("t48_no_busy", busy_o, 0);
      cyc();
    end
    trig_i = '0;
    rd(1, 4'd0);

    // Continuous 5-cycle gates with beam 3 held high.
    mode_i = 1'b1; period_i = 16'd5; holdoff_i = 8'd0; trig_i[3] = 1'b1;
    start_gate();
    k = 0;
    for (int c = 0; c < 17; c++) begin
      check_eq($sformatf("t45_busy_c%0d", c), busy_o, 1);
      check_eq($sformatf("t45_done_c%0d", c), done_o, (c == 5 || c == 10 || c == 15));
      if (done_o) begin
        k++;
        check_eq("t45_seq", snap_seq_o, k);
        rd_req_i = 1'b1; rd_idx_i = 2'd3;
        rd_q.push_back(4'd5);
      end else begin
        rd_req_i = 1'b0;
      end
      cyc();
    end
    rd_req_i = 1'b0;
    check_eq("t45_done_count", k, 3);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0; mode_i = 1'b0; trig_i = '0;
    cyc();
    check_eq("t45_stopped", busy_o, 0);

    cyc(); cyc(); cyc();
    check_eq("rd_queue_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
